// File: rtl/fb_master_arb_if.sv
// Requester and PLB master-write signals for the two-requester framebuffer arbiter.
// The master modport is the arbiter's view; slave is the requesters/bus side.
interface fb_master_arb_if;
  logic        req0_wr_req;
  logic [31:0] req0_addr;
  logic [31:0] req0_data;
  logic        req0_cmdack;
  logic        req0_cmplt;
  logic        req0_error;
  logic        req1_wr_req;
  logic [31:0] req1_addr;
  logic [31:0] req1_data;
  logic        req1_cmdack;
  logic        req1_cmplt;
  logic        req1_error;
  logic        IP2Bus_MstWr_Req;
  logic [31:0] IP2Bus_Mst_Addr;
  logic [31:0] IP2Bus_MstWr_d;
  logic        Bus2IP_Mst_CmdAck;
  logic        Bus2IP_Mst_Cmplt;
  logic        Bus2IP_Mst_Error;
  logic [1:0]  grant;
  logic        busy;

  modport master (
    input  req0_wr_req, req0_addr, req0_data,
    input  req1_wr_req, req1_addr, req1_data,
    input  Bus2IP_Mst_CmdAck, Bus2IP_Mst_Cmplt, Bus2IP_Mst_Error,
    output req0_cmdack, req0_cmplt, req0_error,
    output req1_cmdack, req1_cmplt, req1_error,
    output IP2Bus_MstWr_Req, IP2Bus_Mst_Addr, IP2Bus_MstWr_d,
    output grant, busy
  );

  modport slave (
    output req0_wr_req, req0_addr, req0_data,
    output req1_wr_req, req1_addr, req1_data,
    output Bus2IP_Mst_CmdAck, Bus2IP_Mst_Cmplt, Bus2IP_Mst_Error,
    input  req0_cmdack, req0_cmplt, req0_error,
    input  req1_cmdack, req1_cmplt, req1_error,
    input  IP2Bus_MstWr_Req, IP2Bus_Mst_Addr, IP2Bus_MstWr_d,
    input  grant, busy
  );
endinterface

// File: rtl/fb_master_arb.sv
// Round-robin arbiter sharing one PLB master write port between the fbwriter
// (requester 0) and the fill/clear engine (requester 1), with per-phase timeout.
module fb_master_arb #(
  parameter int unsigned TIMEOUT = 1023
) (
  input logic            PLB_clk,
  input logic            reset,
  fb_master_arb_if.master bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_CMPLT} state_e;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic [1:0]  cmdack_q, cmdack_d;
  logic [1:0]  cmplt_q, cmplt_d;
  logic [1:0]  err_q, err_d;
  logic        mreq_q, mreq_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [15:0] cnt_q, cnt_d;
  logic        last_q, last_d;
  logic [1:0]  req_v;
  logic        win1;

  // A requester still shows wr_req in the cycle its cmplt is visible; mask it
  // so a finished transaction is not issued twice.
  assign req_v = {bus.req1_wr_req, bus.req0_wr_req} & ~cmplt_q;

  always_ff @(posedge PLB_clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      cmdack_q <= '0;
      cmplt_q  <= '0;
      err_q    <= '0;
      mreq_q   <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
      last_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      cmdack_q <= cmdack_d;
      cmplt_q  <= cmplt_d;
      err_q    <= err_d;
      mreq_q   <= mreq_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    cmdack_d = '0;
    cmplt_d  = '0;
    err_d    = '0;
    mreq_d   = mreq_q;
    addr_d   = addr_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    win1     = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req_v) begin
          win1    = req_v[1] & (~req_v[0] | ~last_q);
          grant_d = win1 ? 2'b10 : 2'b01;
          addr_d  = win1 ? bus.req1_addr : bus.req0_addr;
          data_d  = win1 ? bus.req1_data : bus.req0_data;
          last_d  = win1;
          cnt_d   = '0;
          mreq_d  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.Bus2IP_Mst_CmdAck) begin
          cmdack_d = grant_q;
          mreq_d   = 1'b0;
          if (bus.Bus2IP_Mst_Cmplt) begin
            cmplt_d = grant_q;
            err_d   = bus.Bus2IP_Mst_Error ? grant_q : 2'b00;
            grant_d = '0;
            state_d = IDLE;
          end else begin
            cnt_d   = '0;
            state_d = WAIT_CMPLT;
          end
        end else if (cnt_q == TMO_LAST) begin
          cmplt_d = grant_q;
          err_d   = grant_q;
          mreq_d  = 1'b0;
          grant_d = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      WAIT_CMPLT: begin
        if (bus.Bus2IP_Mst_Cmplt) begin
          cmplt_d = grant_q;
          err_d   = bus.Bus2IP_Mst_Error ? grant_q : 2'b00;
          grant_d = '0;
          state_d = IDLE;
        end else if (cnt_q == TMO_LAST) begin
          cmplt_d = grant_q;
          err_d   = grant_q;
          grant_d = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req0_cmdack      = cmdack_q[0];
  assign bus.req0_cmplt       = cmplt_q[0];
  assign bus.req0_error       = err_q[0];
  assign bus.req1_cmdack      = cmdack_q[1];
  assign bus.req1_cmplt       = cmplt_q[1];
  assign bus.req1_error       = err_q[1];
  assign bus.IP2Bus_MstWr_Req = mreq_q;
  assign bus.IP2Bus_Mst_Addr  = addr_q;
  assign bus.IP2Bus_MstWr_d   = data_q;
  assign bus.grant            = grant_q;
  assign bus.busy             = (state_q != IDLE);
endmodule

// File: tb/tb_fb_master_arb.sv
// Directed bench for fb_master_arb: cycle table for single transactions, then
// hand sequences for round-robin, timeout and mid-transaction reset.
module tb_fb_master_arb;
  logic PLB_clk = 1'b0;
  logic reset   = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  fb_master_arb_if bif();

  fb_master_arb #(.TIMEOUT(8)) dut (
    .PLB_clk (PLB_clk),
    .reset   (reset),
    .bus     (bif.master)
  );

  always #5 PLB_clk = ~PLB_clk;

  // {mwr, busy, grant[1:0], cmdack{1,0}, cmplt{1,0}, error{1,0}}
  typedef struct {
    logic        r0, r1;
    logic [31:0] a0, d0, a1, d1;
    logic        ack, cpl, err;
    logic [9:0]  eo;
    logic [31:0] ea, ed;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(logic r0, logic r1, logic [31:0] a0, logic [31:0] d0,
                              logic ack, logic cpl, logic err,
                              logic [9:0] eo, logic [31:0] ea, logic [31:0] ed);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.a0 = a0; v.d0 = d0;
    v.a1 = 32'h2000; v.d1 = 32'h55AA;
    v.ack = ack; v.cpl = cpl; v.err = err;
    v.eo = eo; v.ea = ea; v.ed = ed;
    return v;
  endfunction

  function automatic logic [9:0] outs();
    return {bif.IP2Bus_MstWr_Req, bif.busy, bif.grant,
            bif.req1_cmdack, bif.req0_cmdack, bif.req1_cmplt, bif.req0_cmplt,
            bif.req1_error, bif.req0_error};
  endfunction

  task automatic chk(input string nm, input logic [73:0] act, input logic [73:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge PLB_clk);
    #1;
  endtask

  task automatic drive(input logic r0, input logic r1, input logic ack,
                       input logic cpl, input logic err);
    bif.req0_wr_req       = r0;
    bif.req1_wr_req       = r1;
    bif.Bus2IP_Mst_CmdAck = ack;
    bif.Bus2IP_Mst_Cmplt  = cpl;
    bif.Bus2IP_Mst_Error  = err;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    tbl[0]  = mk(1, 0, 32'h1000, 32'hABCD, 1, 1, 0, 10'b1_1_01_00_00_00, 32'h1000, 32'hABCD);
    tbl[1]  = mk(1, 0, 32'h1000, 32'hABCD, 1, 1, 0, 10'b0_0_00_01_01_00, 32'h1000, 32'hABCD);
    tbl[2]  = mk(1, 0, 32'h1000, 32'hABCD, 1, 1, 0, 10'b0_0_00_00_00_00, 32'h1000, 32'hABCD);
    tbl[3]  = mk(0, 0, 32'h1000, 32'hABCD, 1, 1, 0, 10'b0_0_00_00_00_00, 32'h1000, 32'hABCD);
    tbl[4]  = mk(0, 1, 32'h1000, 32'hABCD, 0, 0, 0, 10'b1_1_10_00_00_00, 32'h2000, 32'h55AA);
    tbl[5]  = mk(0, 1, 32'h1000, 32'hABCD, 1, 0, 0, 10'b0_1_10_10_00_00, 32'h2000, 32'h55AA);
    tbl[6]  = mk(0, 1, 32'h1000, 32'hABCD, 0, 0, 0, 10'b0_1_10_00_00_00, 32'h2000, 32'h55AA);
    tbl[7]  = mk(0, 1, 32'h1000, 32'hABCD, 0, 0, 0, 10'b0_1_10_00_00_00, 32'h2000, 32'h55AA);
    tbl[8]  = mk(0, 1, 32'h1000, 32'hABCD, 0, 1, 0, 10'b0_0_00_00_10_00, 32'h2000, 32'h55AA);
    tbl[9]  = mk(0, 1, 32'h1000, 32'hABCD, 0, 0, 0, 10'b0_0_00_00_00_00, 32'h2000, 32'h55AA);
    tbl[10] = mk(0, 0, 32'h1000, 32'hABCD, 0, 0, 0, 10'b0_0_00_00_00_00, 32'h2000, 32'h55AA);
    tbl[11] = mk(1, 0, 32'h3000, 32'h1234, 0, 0, 0, 10'b1_1_01_00_00_00, 32'h3000, 32'h1234);
    tbl[12] = mk(1, 0, 32'h3000, 32'h1234, 1, 0, 0, 10'b0_1_01_01_00_00, 32'h3000, 32'h1234);
    tbl[13] = mk(1, 0, 32'h3000, 32'h1234, 0, 1, 1, 10'b0_0_00_00_01_01, 32'h3000, 32'h1234);
    tbl[14] = mk(0, 0, 32'h3000, 32'h1234, 1, 1, 1, 10'b0_0_00_00_00_00, 32'h3000, 32'h1234);

    bif.req0_addr = '0; bif.req0_data = '0;
    bif.req1_addr = '0; bif.req1_data = '0;
    drive(0, 0, 0, 0, 0);

    // reset state, with reset still held
    tick();
    tick();
    chk("reset_state", {outs(), bif.IP2Bus_Mst_Addr, bif.IP2Bus_MstWr_d}, '0);
    reset = 1'b0;
    tick();

    foreach (tbl[i]) begin
      bif.req0_addr = tbl[i].a0; bif.req0_data = tbl[i].d0;
      bif.req1_addr = tbl[i].a1; bif.req1_data = tbl[i].d1;
      drive(tbl[i].r0, tbl[i].r1, tbl[i].ack, tbl[i].cpl, tbl[i].err);
      tick();
      chk($sformatf("vec%0d", i), {outs(), bif.IP2Bus_Mst_Addr, bif.IP2Bus_MstWr_d},
          {tbl[i].eo, tbl[i].ea, tbl[i].ed});
    end

    // round-robin: both held high from reset, bus acks+completes immediately
    drive(0, 0, 0, 0, 0);
    do_reset();
    bif.req0_addr = 32'hA000; bif.req0_data = 32'h0A0A;
    bif.req1_addr = 32'hB000; bif.req1_data = 32'h0B0B;
    drive(1, 1, 1, 1, 0);
    for (int t = 0; t < 4; t++) begin
      tick();
      chk($sformatf("rr_issue%0d", t), {outs(), bif.IP2Bus_Mst_Addr, 32'h0},
          (t % 2 == 0) ? {10'b1_1_01_00_00_00, 32'hA000, 32'h0}
                       : {10'b1_1_10_00_00_00, 32'hB000, 32'h0});
      tick();
      chk($sformatf("rr_done%0d", t), {outs(), 64'h0},
          (t % 2 == 0) ? {10'b0_0_00_01_01_00, 64'h0}
                       : {10'b0_0_00_10_10_00, 64'h0});
    end
    drive(0, 0, 0, 0, 0);
    tick();
    tick();

    // timeout in ISSUE after 8 cycles without CmdAck
    drive(1, 0, 0, 0, 0);
    tick();
    chk("tmo_enter", {outs(), 64'h0}, {10'b1_1_01_00_00_00, 64'h0});
    for (int c = 0; c < 7; c++) begin
      tick();
      chk($sformatf("tmo_hold%0d", c), {outs(), 64'h0}, {10'b1_1_01_00_00_00, 64'h0});
    end
    tick();
    chk("tmo_abort", {outs(), 64'h0}, {10'b0_0_00_00_01_01, 64'h0});
    drive(0, 0, 0, 0, 0);
    tick();
    tick();

    // asynchronous reset during WAIT_CMPLT
    drive(0, 1, 0, 0, 0);
    tick();
    drive(0, 1, 1, 0, 0);
    tick();
    chk("rst_pre_wait", {outs(), 64'h0}, {10'b0_1_10_10_00_00, 64'h0});
    drive(0, 1, 0, 0, 0);
    #2 reset = 1'b1;
    #1;
    chk("rst_async", {outs(), bif.IP2Bus_Mst_Addr, bif.IP2Bus_MstWr_d}, '0);
    drive(0, 1, 0, 1, 0);
    tick();
    chk("rst_no_cmplt", {outs(), 64'h0}, '0);
    reset = 1'b0;
    drive(0, 1, 1, 1, 0);
    tick();
    chk("rst_reissue", {outs(), bif.IP2Bus_Mst_Addr, bif.IP2Bus_MstWr_d},
        {10'b1_1_10_00_00_00, 32'hB000, 32'h0B0B});
    tick();
    chk("rst_redone", {outs(), 64'h0}, {10'b0_0_00_10_10_00, 64'h0});
    drive(0, 0, 0, 0, 0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
